// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
// FSM states, grant owner encoding, word size, default lane count.
package dmem_port_arbiter_pkg;

  localparam int WORD_BYTES = 4;
  localparam int DEF_LANES  = 4;

  typedef enum logic [1:0] {
    IDLE,
    VBURST,
    VDRAIN
  } arb_state_e;

  typedef enum logic {
    SCALAR = 1'b0,
    VECTOR = 1'b1
  } owner_e;

  function automatic logic [31:0] laneOffset(
    input logic [31:0] idx
  );
    return idx * 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between scalar/vector MEM stages, arbiter and data memory.
// slave: arbiter side. master: pipelines plus memory side.
interface dmem_port_arbiter_if
  import dmem_port_arbiter_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int AW    = 32
);

  logic              s_req;
  logic              s_we;
  logic [AW-1:0]     s_addr;
  logic [31:0]       s_wdata;
  logic              s_gnt;
  logic              s_stall;
  logic              s_rvalid;
  logic [31:0]       s_rdata;

  logic              v_req;
  logic              v_we;
  logic [AW-1:0]     v_addr;
  logic [32*LANES-1:0] v_wdata;
  logic              v_stall;
  logic              v_done;
  logic [32*LANES-1:0] v_rdata;

  logic              m_en;
  logic              m_we;
  logic [AW-1:0]     m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  modport slave (
    input  s_req, s_we, s_addr, s_wdata,
    output s_gnt, s_stall, s_rvalid, s_rdata,
    input  v_req, v_we, v_addr, v_wdata,
    output v_stall, v_done, v_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output s_req, s_we, s_addr, s_wdata,
    input  s_gnt, s_stall, s_rvalid, s_rdata,
    output v_req, v_we, v_addr, v_wdata,
    input  v_stall, v_done, v_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker (scalar vs vector) holding lastGrant.
// Ports: clk, rst(n), sReq/vReq, en, hold -> sGnt/vGnt.
module arb_rr2
  import dmem_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sReq,
  input  logic vReq,
  input  logic en,
  input  logic hold,
  output logic sGnt,
  output logic vGnt
);

  owner_e lastGrant;

  // Scalar wins a tie only if the vector side won last.
  always_comb begin
    sGnt = 1'b0;
    vGnt = 1'b0;
    if (en && !hold) begin
      if (sReq && (!vReq || lastGrant == VECTOR)) begin
        sGnt = 1'b1;
      end else if (vReq) begin
        vGnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastGrant <= VECTOR;
    end else if (sGnt) begin
      lastGrant <= SCALAR;
    end else if (vGnt) begin
      lastGrant <= VECTOR;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between scalar and vector MEM stages.
// Ports: clk, rst (async, active low), bus (slave modport).
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int AW    = 32
)(
  input logic clk,
  input logic rst,
  dmem_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(LANES);
  typedef logic [CW-1:0] beat_t;
  localparam beat_t LAST = beat_t'(LANES - 1);

  arb_state_e stateQ, stateD;
  beat_t      beatQ, beatD;
  logic       vDoneQ;
  logic       sRvalidQ;
  logic       rdPendQ;
  beat_t      rdLaneQ;
  logic [32*LANES-1:0] vRdataQ;

  logic          sGnt;
  logic          vGnt;
  logic          vReqEff;
  logic          issueV;
  logic [AW-1:0] laneAddr;

  // The done cycle belongs to the old burst; its request is stale.
  assign vReqEff = bus.v_req & ~vDoneQ;

  arb_rr2 uArb (
    .clk  (clk),
    .rst  (rst),
    .sReq (bus.s_req),
    .vReq (vReqEff),
    .en   (rst),
    .hold (stateQ != IDLE),
    .sGnt (sGnt),
    .vGnt (vGnt)
  );

  // beatQ is 0 in IDLE, so it indexes beat 0 on the grant cycle too.
  assign laneAddr = bus.v_addr
                  + AW'(laneOffset(32'(beatQ)));

  always_comb begin
    stateD = stateQ;
    beatD  = beatQ;
    issueV = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (vGnt) begin
          issueV = 1'b1;
          stateD = VBURST;
          beatD  = beat_t'(1);
        end
      end
      VBURST: begin
        issueV = 1'b1;
        if (beatQ == LAST) begin
          stateD = VDRAIN;
          beatD  = '0;
        end else begin
          beatD = beatQ + beat_t'(1);
        end
      end
      VDRAIN: begin
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
        beatD  = '0;
      end
    endcase
  end

  always_comb begin
    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    if (sGnt) begin
      bus.m_en    = 1'b1;
      bus.m_we    = bus.s_we;
      bus.m_addr  = bus.s_addr;
      bus.m_wdata = bus.s_wdata;
    end else if (issueV) begin
      bus.m_en    = 1'b1;
      bus.m_we    = bus.v_we;
      bus.m_addr  = laneAddr;
      bus.m_wdata = bus.v_wdata[{beatQ, 5'b0} +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= IDLE;
      beatQ    <= '0;
      vDoneQ   <= 1'b0;
      sRvalidQ <= 1'b0;
      rdPendQ  <= 1'b0;
      rdLaneQ  <= '0;
    end else begin
      stateQ   <= stateD;
      beatQ    <= beatD;
      vDoneQ   <= (stateQ == VDRAIN);
      sRvalidQ <= sGnt & ~bus.s_we;
      rdPendQ  <= issueV & ~bus.v_we;
      rdLaneQ  <= beatQ;
    end
  end

  // Read data returns one cycle after its beat; land it in that lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vRdataQ <= '0;
    end else if (rdPendQ) begin
      vRdataQ[{rdLaneQ, 5'b0} +: 32] <= bus.m_rdata;
    end
  end

  assign bus.s_gnt    = sGnt;
  assign bus.s_stall  = bus.s_req & ~sGnt;
  assign bus.s_rvalid = sRvalidQ;
  assign bus.s_rdata  = bus.m_rdata;
  assign bus.v_stall  = bus.v_req & ~vDoneQ;
  assign bus.v_done   = vDoneQ;
  assign bus.v_rdata  = vRdataQ;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vectors, cycle-level model
// of the port schedule, and a reactive data memory.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int LANES = 4;
  localparam int AW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.LANES(LANES), .AW(AW)) bus ();

  dmem_port_arbiter #(.LANES(LANES), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [255:0] act,
                              logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] initVal(logic [31:0] a);
    return a ^ 32'hCAFE0000;
  endfunction

  // Memory seen by the DUT, and the model's idea of memory.
  logic [31:0] mem    [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];

  function automatic logic [31:0] memRd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : initVal(a);
  endfunction

  function automatic logic [31:0] refRd(logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initVal(a);
  endfunction

  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_addr] = bus.m_wdata;
      else bus.m_rdata <= memRd(bus.m_addr);
    end
  end

  // Model: a vector grant at cycle T owns the port through T+LANES,
  // done pulses at T+LANES+1.
  int  cyc = 0;
  int  burstStart = -1;
  bit  lastVec = 1'b1;
  bit  sRvExp = 1'b0;
  logic [31:0] sRdExp = '0;
  logic [32*LANES-1:0] vRdExp = '0;

  typedef struct packed {
    logic sGnt;
    logic vGnt;
    logic mEn;
    logic mWe;
    logic [31:0] mAddr;
    logic [31:0] mWdata;
  } exp_t;

  function automatic bit doneExp();
    return burstStart >= 0 && cyc - burstStart == LANES + 1;
  endfunction

  function automatic bit busyExp();
    int p;
    p = cyc - burstStart;
    return burstStart >= 0 && p >= 1 && p <= LANES;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int   p;
    bit   vElig;
    e = '0;
    if (!rst) return e;
    p = cyc - burstStart;
    if (busyExp()) begin
      if (p < LANES) begin
        e.mEn    = 1'b1;
        e.mWe    = bus.v_we;
        e.mAddr  = bus.v_addr + 32'(4 * p);
        e.mWdata = bus.v_wdata[32*p +: 32];
      end
      return e;
    end
    vElig = bus.v_req && !doneExp();
    if (bus.s_req && (!vElig || lastVec)) begin
      e.sGnt   = 1'b1;
      e.mEn    = 1'b1;
      e.mWe    = bus.s_we;
      e.mAddr  = bus.s_addr;
      e.mWdata = bus.s_wdata;
    end else if (vElig) begin
      e.vGnt   = 1'b1;
      e.mEn    = 1'b1;
      e.mWe    = bus.v_we;
      e.mAddr  = bus.v_addr;
      e.mWdata = bus.v_wdata[31:0];
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst) begin
    exp_t e;
    if (!rst) begin
      burstStart = -1;
      lastVec    = 1'b1;
      sRvExp     = 1'b0;
      vRdExp     = '0;
    end else begin
      e = predict();
      if (doneExp()) burstStart = -1;
      sRvExp = e.sGnt && !bus.s_we;
      if (e.sGnt) begin
        if (bus.s_we) refMem[bus.s_addr] = bus.s_wdata;
        else sRdExp = refRd(bus.s_addr);
        lastVec = 1'b0;
      end
      if (e.vGnt) begin
        burstStart = cyc;
        lastVec    = 1'b1;
        for (int i = 0; i < LANES; i++) begin
          logic [31:0] a;
          a = bus.v_addr + 32'(4 * i);
          if (bus.v_we) refMem[a] = bus.v_wdata[32*i +: 32];
          else vRdExp[32*i +: 32] = refRd(a);
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #2;
    e = predict();
    chk("s_gnt", bus.s_gnt, e.sGnt);
    chk("s_stall", bus.s_stall, bus.s_req & ~e.sGnt);
    chk("m_en", bus.m_en, e.mEn);
    if (e.mEn || !rst) begin
      chk("m_we", bus.m_we, e.mWe);
      chk("m_addr", bus.m_addr, e.mAddr);
      chk("m_wdata", bus.m_wdata, e.mWdata);
    end
    chk("s_rvalid", bus.s_rvalid, sRvExp);
    if (sRvExp) chk("s_rdata", bus.s_rdata, sRdExp);
    chk("v_done", bus.v_done, doneExp());
    chk("v_stall", bus.v_stall, bus.v_req & ~doneExp());
    if (!busyExp()) chk("v_rdata", bus.v_rdata, vRdExp);
  end

  logic [31:0] addrQ [$];

  // Called right after a vector request is raised; returns cycles to
  // done, drops v_req on the following negedge.
  task automatic runVec(output int n, output bit sAtDone);
    n = -1;
    sAtDone = 1'b0;
    addrQ.delete();
    for (int k = 0; k < 20; k++) begin
      #3;
      if (bus.m_en && !bus.s_gnt) addrQ.push_back(bus.m_addr);
      if (bus.v_done) begin
        n = k;
        sAtDone = bus.s_gnt;
        @(negedge clk);
        bus.v_req = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL vec_timeout actual=no_done required=done");
    bus.v_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    bit sd;
    bus.s_req = 0; bus.s_we = 0; bus.s_addr = '0; bus.s_wdata = '0;
    bus.v_req = 0; bus.v_we = 0; bus.v_addr = '0; bus.v_wdata = '0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_v_rdata", bus.v_rdata, '0);
    chk("rst_m_en", bus.m_en, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // scalar read, write, read-back
    @(negedge clk);
    bus.s_req = 1; bus.s_addr = 32'h100;
    #3;
    chk("sc_gnt", bus.s_gnt, 1'b1);
    chk("sc_addr", bus.m_addr, 32'h100);
    @(negedge clk);
    bus.s_we = 1; bus.s_addr = 32'h104; bus.s_wdata = 32'h11112222;
    #3;
    chk("sc_rvalid", bus.s_rvalid, 1'b1);
    chk("sc_rdata", bus.s_rdata, 32'hCAFE0100);
    @(negedge clk);
    bus.s_we = 0;
    @(negedge clk);
    bus.s_addr = 32'h700;
    #3;
    chk("sc_wr_rd", bus.s_rdata, 32'h11112222);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      bus.s_addr = 32'h700 + 32'(4 * i);
    end
    @(negedge clk);
    bus.s_req = 0;

    // vector read
    @(negedge clk);
    bus.v_req = 1; bus.v_we = 0; bus.v_addr = 32'h200;
    runVec(n, sd);
    #1;
    chk("vr_lat", 32'(n), 32'(LANES + 1));
    chk("vr_beats", 32'(addrQ.size()), 32'd4);
    for (int i = 0; i < 4 && i < addrQ.size(); i++)
      chk("vr_addr", addrQ[i], 32'h200 + 32'(4 * i));
    chk("vr_data", bus.v_rdata,
        {32'hCAFE020C, 32'hCAFE0208, 32'hCAFE0204, 32'hCAFE0200});

    // tie after reset: scalar first, then vector on the next tie
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    @(negedge clk);
    bus.s_req = 1; bus.s_addr = 32'h300;
    bus.v_req = 1; bus.v_addr = 32'h400;
    #3;
    chk("tie1_sgnt", bus.s_gnt, 1'b1);
    chk("tie1_vstall", bus.v_stall, 1'b1);
    @(negedge clk);
    bus.s_addr = 32'h304;
    #1;
    chk("tie1_rdata", bus.s_rdata, 32'hCAFE0300);
    chk("tie2_sstall", bus.s_stall, 1'b1);
    runVec(n, sd);
    chk("tie2_vfirst", addrQ.size() > 0 ? addrQ[0] : 32'hX, 32'h400);
    chk("tie2_lat", 32'(n), 32'(LANES + 1));
    chk("mid_sgnt_done", sd, 1'b1);
    bus.s_req = 0;
    #1;
    chk("mid_rdata", bus.s_rdata, 32'hCAFE0304);

    // vector write across the address wrap, then read it back
    @(negedge clk);
    bus.v_req = 1; bus.v_we = 1; bus.v_addr = 32'hFFFFFFF8;
    bus.v_wdata = {32'h44444444, 32'h33333333,
                   32'h22222222, 32'h11111111};
    runVec(n, sd);
    chk("vw_beats", 32'(addrQ.size()), 32'd4);
    if (addrQ.size() == 4) begin
      chk("vw_a0", addrQ[0], 32'hFFFFFFF8);
      chk("vw_a1", addrQ[1], 32'hFFFFFFFC);
      chk("vw_a2", addrQ[2], 32'h0);
      chk("vw_a3", addrQ[3], 32'h4);
    end
    chk("vw_m0", memRd(32'hFFFFFFF8), 32'h11111111);
    chk("vw_m3", memRd(32'h4), 32'h44444444);
    chk("vw_keep", bus.v_rdata[31:0], 32'hCAFE0400);
    bus.v_req = 1; bus.v_we = 0;
    runVec(n, sd);
    chk("vw_back", bus.v_rdata,
        {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});

    // reset during beat 2, then re-request
    @(negedge clk);
    bus.v_req = 1; bus.v_addr = 32'h500;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    bus.v_req = 0;
    #1;
    chk("rm_men", bus.m_en, 1'b0);
    chk("rm_vrdata", bus.v_rdata, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    repeat (3) begin
      @(negedge clk);
      #3;
      chk("rm_nodone", bus.v_done, 1'b0);
    end
    @(negedge clk);
    bus.v_req = 1;
    runVec(n, sd);
    chk("rm_lat", 32'(n), 32'(LANES + 1));
    chk("rm_data", bus.v_rdata,
        {32'hCAFE050C, 32'hCAFE0508, 32'hCAFE0504, 32'hCAFE0500});

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
